debounce_bank: RTL

DEBOUNCE_BANK -- requirements
Module: debounce_bank

---
 rtl/debounce_pkg.sv | 31 +++
 rtl/debounce_channel.sv | 94 +++++++++
 rtl/debounce_bank.sv | 43 ++++
 3 files changed

// File: rtl/debounce_pkg.sv
// debounce_pkg: shared constants, helper function and event record for the
// switch debounce bank.
//   clog2()                     ceiling log2, used for counter widths
//   DEBOUNCE_LIMIT_10MS_25MHZ   10 ms of stable input at 25 MHz
//   LONG_LIMIT_1S_25MHZ         1 s long-press hold time at 25 MHz
//   ch_event_t                  per-channel registered pulse group
package debounce_pkg;

  localparam int DEBOUNCE_LIMIT_10MS_25MHZ = 250000;
  localparam int LONG_LIMIT_1S_25MHZ       = 25000000;

  typedef struct packed {
    logic press;
    logic rel;
    logic lng;
  } ch_event_t;

  // Number of bits needed to index 'value' distinct states; clog2(1) == 0.
  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: one switch channel -- 2-flop synchroniser, stability
// counter, debounced level, press/release pulses and long-press timer.
// Ports:
//   clk_i      clock
//   rst_i      asynchronous active-high reset
//   switch_i   raw asynchronous switch level
//   state_o    debounced level, 1 = pressed
//   press_o    one-cycle pulse after debounced 0->1
//   release_o  one-cycle pulse after debounced 1->0
//   long_o     one-cycle pulse when pressed for LONG_LIMIT cycles
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = DEBOUNCE_LIMIT_10MS_25MHZ,
  parameter int LONG_LIMIT     = LONG_LIMIT_1S_25MHZ,
  parameter bit INVERT         = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic switch_i,
  output logic state_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  localparam int CW      = clog2(DEBOUNCE_LIMIT + 1);
  localparam int HW_RAW  = clog2(LONG_LIMIT + 1);
  localparam int HW      = (HW_RAW < 1) ? 1 : HW_RAW;
  localparam bit LONG_EN = (LONG_LIMIT > 0);

  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_LIMIT - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_LIMIT);
  // Only meaningful when LONG_EN; the long pulse is gated otherwise.
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_LIMIT - 1);

  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  ch_event_t     evt_q, evt_d;

  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    evt_d   = '0;

    if (sync2_q == state_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      // Input has differed for DEBOUNCE_LIMIT consecutive cycles: accept it.
      state_d   = sync2_q;
      cnt_d     = '0;
      evt_d.press = sync2_q;
      evt_d.rel   = ~sync2_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    // Hold timer runs off the registered level; it saturates so the long
    // pulse fires at most once per press.
    hold_d = hold_q;
    if (!state_q) begin
      hold_d = '0;
    end else if (LONG_EN && (hold_q != HOLD_MAX)) begin
      hold_d = hold_q + 1'b1;
    end
    evt_d.lng = LONG_EN && state_q && (hold_q == HOLD_LAST);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      state_q <= 1'b0;
      hold_q  <= '0;
      evt_q   <= '0;
    end else begin
      sync1_q <= switch_i ^ INVERT;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      hold_q  <= hold_d;
      evt_q   <= evt_d;
    end
  end

  assign state_o   = state_q;
  assign press_o   = evt_q.press;
  assign release_o = evt_q.rel;
  assign long_o    = evt_q.lng;

endmodule

// File: rtl/debounce_bank.sv
// debounce_bank: NUM_CH independent debounced switch channels.
// Ports:
//   i_Clk      clock for all logic
//   i_Rst      asynchronous active-high reset
//   i_Switch   raw switch levels (ACTIVE_LOW bits are inverted first)
//   o_State    debounced level per channel, 1 = pressed
//   o_Press    one-cycle pulse per channel on debounced 0->1
//   o_Release  one-cycle pulse per channel on debounced 1->0
//   o_Long     one-cycle pulse per channel after LONG_LIMIT pressed cycles
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int                NUM_CH         = 4,
  parameter int                DEBOUNCE_LIMIT = DEBOUNCE_LIMIT_10MS_25MHZ,
  parameter int                LONG_LIMIT     = LONG_LIMIT_1S_25MHZ,
  parameter logic [NUM_CH-1:0] ACTIVE_LOW     = '0
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic [NUM_CH-1:0] i_Switch,
  output logic [NUM_CH-1:0] o_State,
  output logic [NUM_CH-1:0] o_Press,
  output logic [NUM_CH-1:0] o_Release,
  output logic [NUM_CH-1:0] o_Long
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT),
      .LONG_LIMIT     (LONG_LIMIT),
      .INVERT         (ACTIVE_LOW[g])
    ) u_ch (
      .clk_i     (i_Clk),
      .rst_i     (i_Rst),
      .switch_i  (i_Switch[g]),
      .state_o   (o_State[g]),
      .press_o   (o_Press[g]),
      .release_o (o_Release[g]),
      .long_o    (o_Long[g])
    );
  end

endmodule
